// File: rtl/alu_sequencer.sv
// Sequencer that loads A, B and opcode into the ALU datapath over one shared bus,
// waits EXEC_CYCLES for the ALU to settle, then captures result and carry.

module alu_sequencer_checker (
  input logic clk,
  input logic reset,
  input logic load_a,
  input logic load_b,
  input logic load_op,
  input logic busy,
  input logic done
);

  a_one_strobe: assert property (@(posedge clk) disable iff (!reset)
    $onehot0({load_a, load_b, load_op}));

  a_done_not_busy: assert property (@(posedge clk) disable iff (!reset)
    !(done && busy));

endmodule

module alu_sequencer #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] a_in,
  input  logic [7:0] b_in,
  input  logic [2:0] op_in,
  input  logic [7:0] alu_result,
  input  logic       alu_carry,
  output logic [7:0] bus_data,
  output logic       load_a,
  output logic       load_b,
  output logic       load_op,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       carry_out
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_A  = 3'd1,
    S_LOAD_B  = 3'd2,
    S_LOAD_OP = 3'd3,
    S_EXEC    = 3'd4,
    S_CAPTURE = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     state;
  logic [7:0] hold_a;
  logic [7:0] hold_b;
  logic [2:0] hold_op;
  logic [3:0] exec_cnt;

  function automatic logic [7:0] op_bus(input logic [2:0] op);
    return {5'b0_0000, op};
  endfunction

  // Outputs are registered alongside the state: each branch sets what the next state drives.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      hold_a    <= 8'h00;
      hold_b    <= 8'h00;
      hold_op   <= 3'b000;
      exec_cnt  <= 4'h0;
      bus_data  <= 8'h00;
      load_a    <= 1'b0;
      load_b    <= 1'b0;
      load_op   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= 8'h00;
      carry_out <= 1'b0;
    end else begin
      bus_data <= 8'h00;
      load_a   <= 1'b0;
      load_b   <= 1'b0;
      load_op  <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            hold_a   <= a_in;
            hold_b   <= b_in;
            hold_op  <= op_in;
            bus_data <= a_in;
            load_a   <= 1'b1;
            busy     <= 1'b1;
            state    <= S_LOAD_A;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_LOAD_A: begin
          bus_data <= hold_b;
          load_b   <= 1'b1;
          state    <= S_LOAD_B;
        end
        S_LOAD_B: begin
          bus_data <= op_bus(hold_op);
          load_op  <= 1'b1;
          state    <= S_LOAD_OP;
        end
        S_LOAD_OP: begin
          exec_cnt <= EXEC_LOAD;
          state    <= S_EXEC;
        end
        S_EXEC: begin
          if (exec_cnt == 4'h0) begin
            state <= S_CAPTURE;
          end else begin
            exec_cnt <= exec_cnt - 4'h1;
          end
        end
        S_CAPTURE: begin
          result    <= alu_result;
          carry_out <= alu_carry;
          busy      <= 1'b0;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  alu_sequencer_checker u_checker (
    .clk     (clk),
    .reset   (reset),
    .load_a  (load_a),
    .load_b  (load_b),
    .load_op (load_op),
    .busy    (busy),
    .done    (done)
  );

endmodule
